my_cpu16_ctrl: RTL and testbench

Multi-cycle sequencer for the 16-bit CPU datapath: register file, 16-bit ripple ALU and function decoder.
- Fetches instructions from instruction memory over a REQ/ACK handshake and holds them in IR.
- Owns the PC.
- Drives register-file read/write addresses, the write enable and the ALU select lines, one phase per cycle.
- Sits above my_ALU / my_registers in the CPU top and replaces the static IR input.

---
 rtl/my_cpu16_pkg.sv | 41 ++++
 rtl/my_cpu16_fdec.sv | 28 ++
 rtl/my_cpu16_ctrl.sv | 157 +++++++++++++++
 tb/tb_my_cpu16_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/my_cpu16_pkg.sv
// Shared types and constants for the 16-bit CPU sequencer: FSM state encoding,
// opcode/function codes and the ALU select bundle.
package my_cpu16_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StDecode,
      StExec,
      StWb,
      StHalt,
      StFault
   } state_t;

   localparam logic [3:0] OP_ALU  = 4'h0;
   localparam logic [3:0] OP_JMP  = 4'h8;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [3:0] F_ADD = 4'hA;
   localparam logic [3:0] F_SUB = 4'h2;
   localparam logic [3:0] F_AND = 4'hC;
   localparam logic [3:0] F_OR  = 4'hE;
   localparam logic [3:0] F_XOR = 4'hD;
   localparam logic [3:0] F_NOT = 4'hB;

   typedef struct packed {
      logic s_sub;
      logic s_fas;
      logic s_and;
      logic s_or;
      logic s_xor;
      logic s_not;
   } alu_sel_t;

   localparam alu_sel_t SEL_NONE = '0;

   function automatic logic [15:0] jmp_target(input logic [15:0] ir);
      return {4'h0, ir[11:0]};
   endfunction

endpackage

// File: rtl/my_cpu16_fdec.sv
// ALU function decoder: maps IR[7:4] onto the six ALU select lines plus a
// valid flag. Purely combinational; the sequencer gates it by state.
module my_cpu16_fdec
   import my_cpu16_pkg::*;
(
   input  logic [3:0] func,
   output alu_sel_t   sel,
   output logic       valid
);

   always_comb begin
      sel   = SEL_NONE;
      valid = 1'b1;
      unique case (func)
         F_ADD: sel.s_fas = 1'b1;
         F_SUB: begin
            sel.s_fas = 1'b1;
            sel.s_sub = 1'b1;
         end
         F_AND: sel.s_and = 1'b1;
         F_OR:  sel.s_or  = 1'b1;
         F_XOR: sel.s_xor = 1'b1;
         F_NOT: sel.s_not = 1'b1;
         default: valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/my_cpu16_ctrl.sv
// Multi-cycle sequencer: fetches over a REQ/ACK handshake, owns PC and IR and
// drives register-file addresses, write enable and ALU selects phase by phase.
module my_cpu16_ctrl
   import my_cpu16_pkg::*;
#(
   parameter logic [15:0] RESET_PC      = 16'h0000,
   parameter int unsigned FETCH_TIMEOUT = 15
) (
   input  logic        CK,
   input  logic        RST,
   input  logic        START,
   output logic        IMEM_REQ,
   output logic [15:0] IMEM_ADDR,
   input  logic        IMEM_ACK,
   input  logic [15:0] IMEM_DATA,
   output logic [15:0] IR,
   output logic [3:0]  N1,
   output logic [3:0]  N2,
   output logic [3:0]  WN,
   output logic        WE,
   output logic        S_SUB,
   output logic        S_FAS,
   output logic        S_AND,
   output logic        S_OR,
   output logic        S_XOR,
   output logic        S_NOT,
   output logic        BUSY,
   output logic        HALTED,
   output logic        FAULT,
   output logic        ILLEGAL
);

   localparam logic [7:0] CNT_LAST = 8'(FETCH_TIMEOUT - 1);

   state_t      state_q;
   logic [15:0] pc_q;
   logic [15:0] ir_q;
   logic [7:0]  cnt_q;
   logic        req_q;
   logic        we_q;
   alu_sel_t    sel_q;
   logic        busy_q;
   logic        halted_q;
   logic        fault_q;
   logic        illegal_q;

   alu_sel_t    dec_sel;
   logic        dec_valid;
   logic [3:0]  opcode;

   assign opcode = ir_q[15:12];

   my_cpu16_fdec u_fdec (
      .func  (ir_q[7:4]),
      .sel   (dec_sel),
      .valid (dec_valid)
   );

   // All outputs are registered; each transition sets the outputs of the
   // state being entered so they are valid for that whole cycle.
   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         state_q   <= StIdle;
         pc_q      <= RESET_PC;
         ir_q      <= 16'h0000;
         cnt_q     <= 8'd0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         sel_q     <= SEL_NONE;
         busy_q    <= 1'b0;
         halted_q  <= 1'b0;
         fault_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         we_q      <= 1'b0;
         illegal_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (START) begin
                  state_q <= StFetch;
                  req_q   <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            StFetch: begin
               if (IMEM_ACK) begin
                  ir_q    <= IMEM_DATA;
                  pc_q    <= pc_q + 16'd1;
                  cnt_q   <= 8'd0;
                  req_q   <= 1'b0;
                  state_q <= StDecode;
               end else if (cnt_q == CNT_LAST) begin
                  cnt_q   <= cnt_q + 8'd1;
                  req_q   <= 1'b0;
                  busy_q  <= 1'b0;
                  fault_q <= 1'b1;
                  state_q <= StFault;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            StDecode: begin
               state_q <= StExec;
               if (opcode == OP_ALU) begin
                  sel_q     <= dec_valid ? dec_sel : SEL_NONE;
                  illegal_q <= ~dec_valid;
               end
            end
            StExec: begin
               if (opcode == OP_ALU && dec_valid) begin
                  we_q    <= 1'b1;
                  state_q <= StWb;
               end else if (opcode == OP_HALT) begin
                  sel_q    <= SEL_NONE;
                  busy_q   <= 1'b0;
                  halted_q <= 1'b1;
                  state_q  <= StHalt;
               end else begin
                  if (opcode == OP_JMP) begin
                     pc_q <= jmp_target(ir_q);
                  end
                  sel_q   <= SEL_NONE;
                  req_q   <= 1'b1;
                  state_q <= StFetch;
               end
            end
            StWb: begin
               sel_q   <= SEL_NONE;
               req_q   <= 1'b1;
               state_q <= StFetch;
            end
            StHalt: state_q <= StHalt;
            StFault: state_q <= StFault;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign IMEM_REQ  = req_q;
   assign IMEM_ADDR = pc_q;
   assign IR        = ir_q;
   assign N1        = ir_q[11:8];
   assign N2        = ir_q[3:0];
   assign WN        = ir_q[11:8];
   assign WE        = we_q;
   assign S_SUB     = sel_q.s_sub;
   assign S_FAS     = sel_q.s_fas;
   assign S_AND     = sel_q.s_and;
   assign S_OR      = sel_q.s_or;
   assign S_XOR     = sel_q.s_xor;
   assign S_NOT     = sel_q.s_not;
   assign BUSY      = busy_q;
   assign HALTED    = halted_q;
   assign FAULT     = fault_q;
   assign ILLEGAL   = illegal_q;

endmodule

// File: tb/tb_my_cpu16_ctrl.sv
// Directed bench for my_cpu16_ctrl: table of instructions with expected phase
// outputs, plus hand sequences for wait states, timeout, halt, reset and PC wrap.
module tb_my_cpu16_ctrl;

   logic        CK = 1'b0;
   logic        RST = 1'b1;
   logic        START = 1'b0;
   logic        IMEM_ACK = 1'b0;
   logic [15:0] IMEM_DATA = 16'h0000;
   logic        IMEM_REQ;
   logic [15:0] IMEM_ADDR;
   logic [15:0] IR;
   logic [3:0]  N1, N2, WN;
   logic        WE, S_SUB, S_FAS, S_AND, S_OR, S_XOR, S_NOT;
   logic        BUSY, HALTED, FAULT, ILLEGAL;

   logic        b_start = 1'b0;
   logic        b_req;
   logic [15:0] b_addr;
   logic [15:0] b_ir;
   logic [3:0]  b_n1, b_n2, b_wn;
   logic        b_we, b_sub, b_fas, b_and, b_or, b_xor, b_not;
   logic        b_busy, b_halted, b_fault, b_illegal;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 CK = ~CK;

   my_cpu16_ctrl dut (
      .CK(CK), .RST(RST), .START(START), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
      .IMEM_ACK(IMEM_ACK), .IMEM_DATA(IMEM_DATA), .IR(IR), .N1(N1), .N2(N2), .WN(WN),
      .WE(WE), .S_SUB(S_SUB), .S_FAS(S_FAS), .S_AND(S_AND), .S_OR(S_OR), .S_XOR(S_XOR),
      .S_NOT(S_NOT), .BUSY(BUSY), .HALTED(HALTED), .FAULT(FAULT), .ILLEGAL(ILLEGAL)
   );

   my_cpu16_ctrl #(.RESET_PC(16'hFFFF), .FETCH_TIMEOUT(15)) dut_b (
      .CK(CK), .RST(RST), .START(b_start), .IMEM_REQ(b_req), .IMEM_ADDR(b_addr),
      .IMEM_ACK(1'b1), .IMEM_DATA(16'h1000), .IR(b_ir), .N1(b_n1), .N2(b_n2), .WN(b_wn),
      .WE(b_we), .S_SUB(b_sub), .S_FAS(b_fas), .S_AND(b_and), .S_OR(b_or), .S_XOR(b_xor),
      .S_NOT(b_not), .BUSY(b_busy), .HALTED(b_halted), .FAULT(b_fault), .ILLEGAL(b_illegal)
   );

   typedef struct {
      logic [15:0] instr;
      logic [5:0]  sel;   // {sub, fas, and, or, xor, not}
      logic        we;
      logic        ill;
      logic [15:0] next;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CK);
      @(negedge CK);
   endtask

   task automatic do_reset();
      RST = 1'b1;
      START = 1'b0;
      b_start = 1'b0;
      @(negedge CK);
      @(negedge CK);
      RST = 1'b0;
   endtask

   function automatic logic [5:0] sels();
      return {S_SUB, S_FAS, S_AND, S_OR, S_XOR, S_NOT};
   endfunction

   initial begin
      logic [15:0] exp_addr;
      int          fetch_cycles;

      vecs[0] = '{16'h01A2, 6'b010000, 1'b1, 1'b0, 16'h0001};
      vecs[1] = '{16'h0323, 6'b110000, 1'b1, 1'b0, 16'h0002};
      vecs[2] = '{16'h04C5, 6'b001000, 1'b1, 1'b0, 16'h0003};
      vecs[3] = '{16'h04E5, 6'b000100, 1'b1, 1'b0, 16'h0004};
      vecs[4] = '{16'h04D5, 6'b000010, 1'b1, 1'b0, 16'h0005};
      vecs[5] = '{16'h04B5, 6'b000001, 1'b1, 1'b0, 16'h0006};
      vecs[6] = '{16'h0150, 6'b000000, 1'b0, 1'b1, 16'h0007};
      vecs[7] = '{16'h8123, 6'b000000, 1'b0, 1'b0, 16'h0123};
      vecs[8] = '{16'h1000, 6'b000000, 1'b0, 1'b0, 16'h0124};
      vecs[9] = '{16'h0F90, 6'b000000, 1'b0, 1'b1, 16'h0125};

      // Reset state
      do_reset();
      chk("reset_outs", {IMEM_REQ, IR, N1, N2, WN, WE, sels(), BUSY, HALTED, FAULT, ILLEGAL}, 64'd0);
      chk("reset_addr", IMEM_ADDR, 16'h0000);
      chk("b_reset_addr", b_addr, 16'hFFFF);
      chk("b_reset_outs", {b_req, b_ir, b_n1, b_n2, b_wn, b_we, b_sub, b_fas, b_and, b_or,
                           b_xor, b_not, b_busy, b_halted, b_fault, b_illegal}, 64'd0);

      // Table-driven instruction stream, zero-wait ACK
      IMEM_ACK = 1'b1;
      START = 1'b1;
      step();
      START = 1'b0;
      exp_addr = 16'h0000;
      for (int i = 0; i < 10; i++) begin
         IMEM_DATA = vecs[i].instr;
         chk($sformatf("v%0d_fetch_req", i), {IMEM_REQ, BUSY}, 2'b11);
         chk($sformatf("v%0d_fetch_addr", i), IMEM_ADDR, exp_addr);
         step();
         chk($sformatf("v%0d_dec_n1n2", i), {N1, N2}, {vecs[i].instr[11:8], vecs[i].instr[3:0]});
         chk($sformatf("v%0d_dec_quiet", i), {IMEM_REQ, WE, sels(), ILLEGAL, BUSY}, 10'b1);
         step();
         chk($sformatf("v%0d_exec_sel", i), sels(), vecs[i].sel);
         chk($sformatf("v%0d_exec_ill_we", i), {ILLEGAL, WE}, {vecs[i].ill, 1'b0});
         step();
         if (vecs[i].we) begin
            chk($sformatf("v%0d_wb_we_wn", i), {WE, WN}, {1'b1, vecs[i].instr[11:8]});
            chk($sformatf("v%0d_wb_sel", i), {sels(), ILLEGAL}, {vecs[i].sel, 1'b0});
            step();
         end
         chk($sformatf("v%0d_next_quiet", i), {WE, sels(), ILLEGAL}, 8'd0);
         exp_addr = vecs[i].next;
      end
      chk("stream_end_addr", IMEM_ADDR, 16'h0125);

      // ACK delayed 3 cycles
      do_reset();
      IMEM_ACK = 1'b0;
      IMEM_DATA = 16'h01A2;
      START = 1'b1;
      step();
      START = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("wait%0d_req_addr_fault", i), {IMEM_REQ, IMEM_ADDR, FAULT}, {1'b1, 16'h0, 1'b0});
         if (i == 3) IMEM_ACK = 1'b1;
         step();
      end
      chk("wait_decode", {IMEM_REQ, N1, N2, FAULT}, {1'b0, 4'h1, 4'h2, 1'b0});

      // ACK withheld -> FAULT after FETCH_TIMEOUT cycles
      do_reset();
      IMEM_ACK = 1'b0;
      START = 1'b1;
      step();
      START = 1'b0;
      fetch_cycles = 0;
      for (int i = 0; i < 40 && !FAULT; i++) begin
         if (IMEM_REQ) fetch_cycles++;
         step();
      end
      chk("timeout_fault", FAULT, 1'b1);
      chk("timeout_cycles", fetch_cycles, 15);
      chk("fault_outs", {IMEM_REQ, BUSY}, 2'b00);
      START = 1'b1;
      repeat (3) step();
      START = 1'b0;
      chk("fault_sticky", {FAULT, IMEM_REQ, BUSY}, 3'b100);
      do_reset();
      chk("fault_cleared", FAULT, 1'b0);

      // HALT
      IMEM_ACK = 1'b1;
      IMEM_DATA = 16'hF000;
      START = 1'b1;
      step();
      START = 1'b0;
      step();
      step();
      chk("halt_exec", {HALTED, BUSY}, 2'b01);
      step();
      chk("halt_state", {HALTED, BUSY, IMEM_REQ}, 3'b100);
      START = 1'b1;
      repeat (3) step();
      START = 1'b0;
      chk("halt_sticky", {HALTED, BUSY, IMEM_REQ}, 3'b100);

      // RST asserted mid-WB
      do_reset();
      IMEM_DATA = 16'h01A2;
      START = 1'b1;
      step();
      START = 1'b0;
      repeat (3) step();
      chk("wb_we_before_rst", WE, 1'b1);
      #1 RST = 1'b1;
      #1;
      chk("rst_wb_we_drop", {WE, BUSY, sels()}, 8'd0);
      chk("rst_wb_pc", IMEM_ADDR, 16'h0000);
      @(negedge CK);
      RST = 1'b0;
      step();
      chk("rst_wb_idle", {IMEM_REQ, BUSY, WE}, 3'b000);

      // PC wrap on the RESET_PC=FFFF instance
      do_reset();
      b_start = 1'b1;
      step();
      b_start = 1'b0;
      chk("wrap_fetch_addr", {b_req, b_addr}, {1'b1, 16'hFFFF});
      step();
      step();
      step();
      chk("wrap_next_addr", {b_req, b_we, b_addr}, {1'b1, 1'b0, 16'h0000});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
